cdb_arbiter: RTL and testbench

Arbitrates functional-unit result producers (ALU, branch unit, load path from the LSQ, multiplier) onto the two common data buses, `cdb1` and `cdb2`. The scheduler, reservation stations, ROB and map table consume these buses. The block grants up to two completing requesters per cycle in round-robin order and drives registered broadcasts one cycle later. It counts cycles where demand exceeds bus capacity, for performance tuning.

---
 rtl/cdb_arbiter.sv | 118 +++++++++++
 tb/tb_cdb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing completing results onto the registered cdb1/cdb2 broadcast buses.
// Define CDB_DUAL_PORT_EN for two grants per cycle; when undefined only cdb1 is driven and cdb2 is tied to 0.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [TAG_W-1:0]          cdb1_tag,
  output logic [DATA_W-1:0]         cdb1_value,
  output logic [TAG_W-1:0]          cdb2_tag,
  output logic [DATA_W-1:0]         cdb2_value,
  output logic [31:0]               conflict_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  g1_idx;
  logic              g1_vld;
  logic              conflict;
  logic [TAG_W-1:0]  tag_a [NUM_REQ];
  logic [DATA_W-1:0] val_a [NUM_REQ];
`ifdef CDB_DUAL_PORT_EN
  logic [PTR_W-1:0]  g2_idx;
  logic              g2_vld;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_a[i] = req_tag[i*TAG_W +: TAG_W];
      val_a[i] = req_value[i*DATA_W +: DATA_W];
    end
  end

  // Tag-0 requests are acknowledged and dropped without taking a slot or counting as conflicts.
  always_comb begin
    req_ready = '0;
    g1_vld    = 1'b0;
    g1_idx    = '0;
    nxt_ptr   = rr_ptr;
    conflict  = 1'b0;
    idx       = '0;
`ifdef CDB_DUAL_PORT_EN
    g2_vld    = 1'b0;
    g2_idx    = '0;
`endif
    if (reset && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (req_valid[idx]) begin
          if (tag_a[idx] == '0) begin
            req_ready[idx] = 1'b1;
          end else if (!g1_vld) begin
            g1_vld         = 1'b1;
            g1_idx         = idx;
            req_ready[idx] = 1'b1;
            nxt_ptr        = PTR_W'((int'(idx) + 1) % NUM_REQ);
`ifdef CDB_DUAL_PORT_EN
          end else if (!g2_vld) begin
            g2_vld         = 1'b1;
            g2_idx         = idx;
            req_ready[idx] = 1'b1;
            nxt_ptr        = PTR_W'((int'(idx) + 1) % NUM_REQ);
`endif
          end else begin
            conflict = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr         <= '0;
      cdb1_tag       <= '0;
      cdb1_value     <= '0;
      conflict_count <= '0;
    end else if (flush) begin
      cdb1_tag   <= '0;
      cdb1_value <= '0;
    end else begin
      rr_ptr     <= nxt_ptr;
      cdb1_tag   <= g1_vld ? tag_a[g1_idx] : '0;
      cdb1_value <= g1_vld ? val_a[g1_idx] : '0;
      if (conflict && conflict_count != 32'hFFFF_FFFF)
        conflict_count <= conflict_count + 32'd1;
    end
  end

`ifdef CDB_DUAL_PORT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb2_tag   <= '0;
      cdb2_value <= '0;
    end else if (flush) begin
      cdb2_tag   <= '0;
      cdb2_value <= '0;
    end else begin
      cdb2_tag   <= g2_vld ? tag_a[g2_idx] : '0;
      cdb2_value <= g2_vld ? val_a[g2_idx] : '0;
    end
  end
`else
  assign cdb2_tag   = '0;
  assign cdb2_value = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a list-based reference model predicts accepts and broadcasts.
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TW = 32;
`ifdef CDB_DUAL_PORT_EN
  localparam int SLOTS = 2;
`else
  localparam int SLOTS = 1;
`endif

  typedef struct {
    logic [TW-1:0] t1;
    logic [DW-1:0] v1;
    logic [TW-1:0] t2;
    logic [DW-1:0] v2;
    logic [31:0]   cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [NR-1:0]    req_valid;
  logic [NR*TW-1:0] req_tag;
  logic [NR*DW-1:0] req_value;
  logic [NR-1:0]    req_ready;
  logic [TW-1:0]    cdb1_tag;
  logic [DW-1:0]    cdb1_value;
  logic [TW-1:0]    cdb2_tag;
  logic [DW-1:0]    cdb2_value;
  logic [31:0]      conflict_count;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t          cdb_q[$];
  logic [NR-1:0] rdy_q[$];

  logic [TW-1:0] pend_tag [NR];
  logic [DW-1:0] pend_val [NR];
  bit            pend_v   [NR];
  int            rr      = 0;
  logic [31:0]   exp_cnt = 0;

  cdb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
    .req_ready(req_ready),
    .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
    .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
    pend_v[i]   = 1'b1;
    pend_tag[i] = t;
    pend_val[i] = v;
  endtask

  // Drive the pending requests for one cycle and predict the outcome of the coming edge.
  task automatic step(input bit fl);
    logic [NR-1:0] rdy = '0;
    int            granted[$];
    bit            conf = 1'b0;
    exp_t          e;
    flush = fl;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = pend_v[i];
      req_tag[i*TW +: TW]  = pend_tag[i];
      req_value[i*DW +: DW] = pend_val[i];
    end
    e.t1 = '0; e.v1 = '0; e.t2 = '0; e.v2 = '0;
    if (!fl) begin
      for (int k = 0; k < NR; k++) begin
        int r = (rr + k) % NR;
        if (pend_v[r]) begin
          if (pend_tag[r] == '0) rdy[r] = 1'b1;
          else if (granted.size() < SLOTS) begin
            granted.push_back(r);
            rdy[r] = 1'b1;
          end else conf = 1'b1;
        end
      end
      if (granted.size() > 0) begin
        e.t1 = pend_tag[granted[0]];
        e.v1 = pend_val[granted[0]];
        rr   = (granted[granted.size()-1] + 1) % NR;
      end
      if (granted.size() > 1) begin
        e.t2 = pend_tag[granted[1]];
        e.v2 = pend_val[granted[1]];
      end
      if (conf && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
    end
    e.cnt = exp_cnt;
    rdy_q.push_back(rdy);
    cdb_q.push_back(e);
    for (int i = 0; i < NR; i++) if (rdy[i]) pend_v[i] = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial forever begin
    @(negedge clk);
    if (rdy_q.size() > 0) chk("req_ready", 32'(req_ready), 32'(rdy_q.pop_front()));
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (cdb_q.size() > 0) begin
      e = cdb_q.pop_front();
      chk("cdb1_tag", cdb1_tag, e.t1);
      chk("cdb1_value", cdb1_value, e.v1);
      chk("cdb2_tag", cdb2_tag, e.t2);
      chk("cdb2_value", cdb2_value, e.v2);
      chk("conflict_count", conflict_count, e.cnt);
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend_v[i]   = 1'b0;
      pend_tag[i] = '0;
      pend_val[i] = '0;
      req_tag[i*TW +: TW]   = TW'(i + 1);
      req_value[i*DW +: DW] = DW'(32'h100 + i);
    end
    req_valid = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_cdb1", cdb1_tag, 32'd0);
      chk("rst_cdb2", cdb2_tag, 32'd0);
      chk("rst_count", conflict_count, 32'd0);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;

    // all four requesters at once: rotation and conflict counting
    for (int i = 0; i < NR; i++) add(i, TW'(i + 1), DW'(32'hA0 + i));
    repeat (5) step(1'b0);

    // leave the pointer at 3, then wrap-around
    add(2, 32'd11, 32'hB2);
    step(1'b0);
    add(0, 32'd9, 32'hC0);
    add(3, 32'd5, 32'hC3);
    repeat (3) step(1'b0);

    // tag-0 discard
    add(0, 32'd0, 32'hD0);
    add(1, 32'd7, 32'hD1);
    repeat (2) step(1'b0);

    // flush: broadcast of tag 6 stays visible while the flush squashes the next grant
    add(2, 32'd6, 32'hE2);
    step(1'b0);
    add(2, 32'd8, 32'hE8);
    step(1'b1);
    repeat (2) step(1'b0);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!pend_v[i] && $urandom_range(0, 1) == 1)
          add(i, TW'($urandom_range(0, 12)), DW'($urandom));
      step($urandom_range(0, 9) == 0);
    end
    repeat (8) step(1'b0);

    // asynchronous reset while a broadcast is on the bus
    add(1, 32'h33, 32'h44);
    step(1'b0);
    req_valid = '1;
    #1;
    reset = 1'b0;
    #1;
    chk("async_cdb1_tag", cdb1_tag, 32'd0);
    chk("async_cdb1_value", cdb1_value, 32'd0);
    chk("async_count", conflict_count, 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
